// File: rtl/square_wave_meter_if.sv
// Signal bundle between a square-wave source and square_wave_meter.
// The source drives square_wave; the meter drives every measurement result.
interface square_wave_meter_if #(
    parameter int CNT_W = 16
);
    logic             square_wave;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic [6:0]       duty_pct;
    logic             duty_valid;
    logic             locked;
    logic             timeout;

    modport master (
        output square_wave,
        input  period, high_time, valid, duty_pct, duty_valid, locked, timeout
    );

    modport slave (
        input  square_wave,
        output period, high_time, valid, duty_pct, duty_valid, locked, timeout
    );
endinterface

// File: rtl/square_wave_meter.sv
// Measures period, high time and duty cycle of an asynchronous square wave,
// counting in clk_100kHz cycles; duty comes from a 7-bit sequential divider.
module square_wave_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic                clk_100kHz,
    input  logic                rst,
    square_wave_meter_if.slave  bus
);
    localparam int               NUM_W   = CNT_W + 7;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [NUM_W-1:0] HUNDRED = NUM_W'(100);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    // Input path
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES:0]   warm_q, warm_d;
    logic                   lvl_prev_q, lvl_prev_d;
    logic                   level, armed, rise, fall;

    // Measurement
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_time_q, high_time_d;
    logic                   valid_q, valid_d;
    logic                   locked_q, locked_d;
    logic                   timeout_q, timeout_d;
    logic                   publish;

    // Duty divider
    logic [NUM_W-1:0]       rem_q, rem_d;
    logic [NUM_W-1:0]       dsh_q, dsh_d;
    logic [6:0]             quo_q, quo_d;
    logic [2:0]             step_q, step_d;
    logic                   busy_q, busy_d;
    logic [6:0]             duty_pct_q, duty_pct_d;
    logic                   duty_valid_q, duty_valid_d;

    // warm_q masks the edge detector until prev holds a genuinely sampled
    // level, so the level present at reset release never looks like an edge.
    assign level = sync_q[SYNC_STAGES-1];
    assign armed = warm_q[SYNC_STAGES];
    assign rise  = armed &  level & ~lvl_prev_q;
    assign fall  = armed & ~level &  lvl_prev_q;

    always_comb begin
        // NOTE: every _d gets its default first, so no branch can infer a latch.
        sync_d       = {sync_q[SYNC_STAGES-2:0], bus.square_wave};
        warm_d       = {warm_q[SYNC_STAGES-1:0], 1'b1};
        lvl_prev_d   = level;
        state_d      = state_q;
        hi_lat_d     = hi_lat_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        valid_d      = 1'b0;
        locked_d     = locked_q;
        timeout_d    = timeout_q;
        publish      = 1'b0;
        rem_d        = rem_q;
        dsh_d        = dsh_q;
        quo_d        = quo_q;
        step_d       = step_q;
        busy_d       = busy_q;
        duty_pct_d   = duty_pct_q;
        duty_valid_d = 1'b0;

        if (rise) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (fall) begin
                    hi_lat_d = cnt_q;
                    state_d  = S_LOW;
                end else if (cnt_q == CNT_MAX) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_LOW: begin
                if (rise) begin
                    publish = 1'b1;
                    state_d = S_HIGH;
                end else if (cnt_q == CNT_MAX) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (publish) begin
            period_d    = cnt_q;
            high_time_d = hi_lat_q;
            valid_d     = 1'b1;
            locked_d    = 1'b1;
            timeout_d   = 1'b0;
        end

        // Quotient < 100 < 2^7, so comparing against period<<6 .. period<<0
        // yields all seven bits; a fresh measurement restarts the division.
        if (publish) begin
            rem_d  = NUM_W'(hi_lat_q) * HUNDRED;
            dsh_d  = {1'b0, cnt_q, 6'b0};
            quo_d  = '0;
            step_d = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (step_q == 3'd7) begin
                duty_pct_d   = quo_q;
                duty_valid_d = 1'b1;
                busy_d       = 1'b0;
            end else begin
                if (rem_q >= dsh_q) begin
                    rem_d = rem_q - dsh_q;
                    quo_d = {quo_q[5:0], 1'b1};
                end else begin
                    quo_d = {quo_q[5:0], 1'b0};
                end
                dsh_d  = dsh_q >> 1;
                step_d = step_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_100kHz or posedge rst) begin
        if (rst) begin
            sync_q       <= '0;
            warm_q       <= '0;
            lvl_prev_q   <= 1'b0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            hi_lat_q     <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            valid_q      <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
            rem_q        <= '0;
            dsh_q        <= '0;
            quo_q        <= '0;
            step_q       <= '0;
            busy_q       <= 1'b0;
            duty_pct_q   <= '0;
            duty_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            sync_q       <= sync_d;
            warm_q       <= warm_d;
            lvl_prev_q   <= lvl_prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_lat_q     <= hi_lat_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            valid_q      <= valid_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
            rem_q        <= rem_d;
            dsh_q        <= dsh_d;
            quo_q        <= quo_d;
            step_q       <= step_d;
            busy_q       <= busy_d;
            duty_pct_q   <= duty_pct_d;
            duty_valid_q <= duty_valid_d;
        end
    end

    assign bus.period     = period_q;
    assign bus.high_time  = high_time_q;
    assign bus.valid      = valid_q;
    assign bus.duty_pct   = duty_pct_q;
    assign bus.duty_valid = duty_valid_q;
    assign bus.locked     = locked_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_square_wave_meter.sv
// Scoreboard bench for square_wave_meter: the driver predicts measurements from
// the edge times it drives; a monitor pops and compares on valid / duty_valid.
module tb_square_wave_meter;
    localparam int CNT_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int MAX_CNT     = (1 << CNT_W) - 1;

    logic clk_100kHz = 1'b0;
    logic rst        = 1'b1;

    square_wave_meter_if #(.CNT_W(CNT_W)) wv ();

    square_wave_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_100kHz(clk_100kHz),
        .rst       (rst),
        .bus       (wv)
    );

    always #5 clk_100kHz = ~clk_100kHz;

    typedef struct {
        int per;
        int hi;
    } meas_t;

    meas_t vq[$];
    int    dq[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic note_unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: output pulsed with nothing expected", name);
    endtask

    // ---------------- monitor ----------------
    int    mon_cyc        = 0;
    int    last_valid_cyc = -1000;
    meas_t mon_m;
    int    mon_d;

    always @(negedge clk_100kHz) begin
        mon_cyc++;
        if (!rst) begin
            if (wv.valid) begin
                if (vq.size() == 0) begin
                    note_unexpected("valid");
                end else begin
                    mon_m = vq.pop_front();
                    check("period", wv.period, mon_m.per);
                    check("high_time", wv.high_time, mon_m.hi);
                    check("locked at valid", wv.locked, 1);
                    check("timeout at valid", wv.timeout, 0);
                end
                last_valid_cyc = mon_cyc;
            end
            if (wv.duty_valid) begin
                if (dq.size() == 0) begin
                    note_unexpected("duty_valid");
                end else begin
                    mon_d = dq.pop_front();
                    check("duty_pct", wv.duty_pct, mon_d);
                    check("duty latency", mon_cyc - last_valid_cyc, 8);
                end
            end
        end
    end

    // ---------------- driver + reference model ----------------
    int t_now     = 0;
    bit sw_lvl    = 1'b0;
    int rises     = 0;
    int last_rise = 0;
    int last_fall = 0;
    bit pending   = 1'b0;
    int pending_val = 0;
    int committed = 0;

    task automatic hold(input int n);
        repeat (n) begin
            @(negedge clk_100kHz);
            t_now++;
        end
    endtask

    // A rise closes the previous period. The previous division survives only
    // if this new measurement arrives more than 8 cycles after it.
    task automatic model_rise();
        meas_t m;
        if (rises > 0) begin
            m.per = t_now - last_rise;
            m.hi  = last_fall - last_rise;
            vq.push_back(m);
            if (pending) begin
                if (m.per > 8) committed = pending_val;
                else void'(dq.pop_back());
            end
            pending     = 1'b1;
            pending_val = (m.hi * 100) / m.per;
            dq.push_back(pending_val);
        end
        rises++;
        last_rise = t_now;
    endtask

    task automatic set_wave(input bit v, input int n);
        if (v && !sw_lvl) model_rise();
        else if (!v && sw_lvl) last_fall = t_now;
        sw_lvl         = v;
        wv.square_wave = v;
        hold(n);
    endtask

    task automatic play(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            set_wave(1'b1, h);
            set_wave(1'b0, l);
        end
    endtask

    task automatic finish_burst();
        set_wave(1'b1, 30);
        if (pending) committed = pending_val;
        pending = 1'b0;
        check("valid queue drained", vq.size(), 0);
        check("duty queue drained", dq.size(), 0);
        check("duty_pct settled", wv.duty_pct, committed);
    endtask

    task automatic clear_model();
        vq.delete();
        dq.delete();
        rises     = 0;
        pending   = 1'b0;
        committed = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " period"}, wv.period, 0);
        check({tag, " high_time"}, wv.high_time, 0);
        check({tag, " valid"}, wv.valid, 0);
        check({tag, " duty_pct"}, wv.duty_pct, 0);
        check({tag, " duty_valid"}, wv.duty_valid, 0);
        check({tag, " locked"}, wv.locked, 0);
        check({tag, " timeout"}, wv.timeout, 0);
    endtask

    task automatic do_reset(input bit toggle);
        @(negedge clk_100kHz);
        t_now++;
        rst = 1'b1;
        repeat (12) begin
            @(negedge clk_100kHz);
            t_now++;
            if (toggle) wv.square_wave = 1'($urandom_range(0, 1));
        end
        check_all_zero("in reset");
        clear_model();
        sw_lvl = wv.square_wave;
        rst    = 1'b0;
        hold(6);
    endtask

    initial begin
        int n;
        int elapsed;
        int h;
        int l;
        int np;

        wv.square_wave = 1'b0;

        // Reset with the input toggling, then period 100 / high 30.
        do_reset(1'b1);
        set_wave(1'b0, 5);
        play(30, 70, 4);
        finish_burst();
        check("locked after lock-in", wv.locked, 1);

        // Input high through reset release, then period 40 / high 10.
        wv.square_wave = 1'b1;
        do_reset(1'b0);
        set_wave(1'b0, 17);
        play(10, 30, 3);
        finish_burst();
        check("locked before idle", wv.locked, 1);
        check("timeout before idle", wv.timeout, 0);

        // Hold low until timeout.
        set_wave(1'b0, 0);
        n = 0;
        while (!wv.timeout && n < 70000) begin
            hold(1);
            n++;
        end
        elapsed = t_now - last_rise;
        check("timeout set", wv.timeout, 1);
        check("timeout delay in window", (elapsed >= MAX_CNT && elapsed <= MAX_CNT + 8), 1);
        check("locked cleared by timeout", wv.locked, 0);
        check("period held over timeout", wv.period, 40);
        check("high_time held over timeout", wv.high_time, 10);
        check("duty_pct held over timeout", wv.duty_pct, 25);
        rises = 0;

        // Resume: timeout stays until the next valid.
        set_wave(1'b1, 10);
        set_wave(1'b0, 30);
        check("timeout sticky before valid", wv.timeout, 1);
        play(10, 30, 2);
        finish_burst();
        check("timeout cleared", wv.timeout, 0);
        check("relocked", wv.locked, 1);

        // Period 4 / high 2: every division is aborted.
        set_wave(1'b0, 2);
        play(2, 2, 10);
        check("valid queue drained fast", vq.size(), 0);
        check("duty_pct held while aborting", wv.duty_pct, committed);

        // Asynchronous reset while in LOW.
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async reset");
        @(negedge clk_100kHz);
        t_now++;
        clear_model();
        rst = 1'b0;
        hold(6);

        // Period 200 / high 150 after reset.
        set_wave(1'b0, 3);
        play(150, 50, 2);
        finish_burst();
        check("duty 75", wv.duty_pct, 75);

        // Randomised continuous bursts.
        for (int b = 0; b < 6; b++) begin
            np = int'($urandom_range(3, 6));
            for (int p = 0; p < np; p++) begin
                h = int'($urandom_range(1, 40));
                l = int'($urandom_range(1, 40));
                if (h + l == 8) l++;
                play(h, l, 1);
            end
            finish_burst();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        bad++;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
